// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-drive signals between the issue controller, its producer, consumer and ALU.
// The slave modport is the controller's view; master is the surrounding environment.
interface alu_issue_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] alu_in0;
  logic [XLEN-1:0] alu_in1;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_out;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, pc, alu_out, out_ready,
    output in_ready, alu_in0, alu_in1, alu_op, out_valid, out_data, out_rd, out_illegal
  );

  modport master (
    output in_valid, instr, rs1_val, rs2_val, pc, alu_out, out_ready,
    input  in_ready, alu_in0, alu_in1, alu_op, out_valid, out_data, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle RV32I issue controller: decodes one instruction, sequences a 1-bit-per-op
// shifting ALU, and hands the result to writeback over valid/ready.
module alu_issue_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_ctrl_if.slave     bus_io
);
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpSra = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0110;
  localparam logic [3:0] OpSll = 4'b0111;
  localparam logic [3:0] OpLui = 4'b1000;

  typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] in0_q, in0_d;  // doubles as the shift accumulator
  logic [31:0] in1_q, in1_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic        dec_ill, dec_shift;
  logic [3:0]  dec_op;
  logic [31:0] dec_in1;
  logic [4:0]  dec_shamt;

  assign opcode = bus_io.instr[6:0];
  assign funct3 = bus_io.instr[14:12];
  assign funct7 = bus_io.instr[31:25];
  assign imm_i  = {{20{bus_io.instr[31]}}, bus_io.instr[31:20]};

  always_comb begin
    dec_ill   = 1'b1;
    dec_shift = 1'b0;
    dec_op    = OpAnd;
    dec_in1   = bus_io.rs2_val;
    dec_shamt = bus_io.rs2_val[4:0];
    if (opcode == 7'b0110011 || opcode == 7'b0010011) begin
      if (opcode == 7'b0010011) begin
        dec_in1   = imm_i;
        dec_shamt = bus_io.instr[24:20];
      end
      case (funct3)
        3'b000: begin
          if (opcode == 7'b0010011 || funct7 == 7'b0000000) begin
            dec_ill = 1'b0;
            dec_op  = OpAdd;
          end else if (funct7 == 7'b0100000) begin
            dec_ill = 1'b0;
            dec_op  = OpSub;
          end
        end
        3'b111: begin
          dec_ill = (opcode == 7'b0110011) && (funct7 != 7'b0000000);
          dec_op  = OpAnd;
        end
        3'b110: begin
          dec_ill = (opcode == 7'b0110011) && (funct7 != 7'b0000000);
          dec_op  = OpOr;
        end
        3'b001: begin
          dec_ill   = funct7 != 7'b0000000;
          dec_shift = 1'b1;
          dec_op    = OpSll;
        end
        3'b101: begin
          dec_ill   = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          dec_shift = 1'b1;
          dec_op    = funct7[5] ? OpSra : OpSrl;
        end
        default: dec_ill = 1'b1;
      endcase
    end else if (opcode == 7'b0110111 || opcode == 7'b0010111) begin
      dec_ill = 1'b0;
      dec_op  = OpLui;
      dec_in1 = (opcode == 7'b0010111) ? bus_io.pc : 32'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    in0_d     = in0_q;
    in1_d     = in1_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          rd_d      = bus_io.instr[11:7];
          op_d      = dec_op;
          in0_d     = (dec_op == OpLui) ? {12'd0, bus_io.instr[31:12]} : bus_io.rs1_val;
          in1_d     = dec_in1;
          cnt_d     = dec_shamt;
          illegal_d = dec_ill;
          if (dec_ill) begin
            data_d  = 32'd0;
            state_d = StDone;
          end else if (dec_shift && dec_shamt == 5'd0) begin
            data_d  = bus_io.rs1_val;
            state_d = StDone;
          end else if (dec_shift) begin
            state_d = StShift;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        data_d  = bus_io.alu_out;
        state_d = StDone;
      end
      StShift: begin
        in0_d = bus_io.alu_out;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          data_d  = bus_io.alu_out;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in0_q     <= 32'd0;
      in1_q     <= 32'd0;
      op_q      <= OpAnd;
      cnt_q     <= 5'd0;
      rd_q      <= 5'd0;
      data_q    <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in0_q     <= in0_d;
      in1_q     <= in1_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    bus_io.alu_in0 = 32'd0;
    bus_io.alu_in1 = 32'd0;
    bus_io.alu_op  = OpAnd;
    if (state_q == StExec) begin
      bus_io.alu_in0 = in0_q;
      bus_io.alu_in1 = in1_q;
      bus_io.alu_op  = op_q;
    end else if (state_q == StShift) begin
      bus_io.alu_in0 = in0_q;
      bus_io.alu_op  = op_q;
    end
  end

  // Gating with rst_n keeps in_ready low while reset is asserted.
  assign bus_io.in_ready    = (state_q == StIdle) && rst_n;
  assign bus_io.out_valid   = state_q == StDone;
  assign bus_io.out_data    = data_q;
  assign bus_io.out_rd      = rd_q;
  assign bus_io.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural single-step ALU in the loop.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.alu_out = 32'd0;
    case (bus.alu_op)
      4'b0000: bus.alu_out = bus.alu_in0 & bus.alu_in1;
      4'b0001: bus.alu_out = bus.alu_in0 | bus.alu_in1;
      4'b0010: bus.alu_out = bus.alu_in0 + bus.alu_in1;
      4'b0011: bus.alu_out = bus.alu_in0 - bus.alu_in1;
      4'b0100: bus.alu_out = {bus.alu_in0[31], bus.alu_in0[31:1]};
      4'b0110: bus.alu_out = {1'b0, bus.alu_in0[31:1]};
      4'b0111: bus.alu_out = {bus.alu_in0[30:0], 1'b0};
      4'b1000: bus.alu_out = {bus.alu_in0[19:0], 12'd0} + bus.alu_in1;
      default: bus.alu_out = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pcv);
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.rs1_val  = rs1;
    bus.rs2_val  = rs2;
    bus.pc       = pcv;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.instr    = 32'h0000_0013;
  endtask

  // Issue, time the result, count cycles the ALU saw exp_op, then hand off after `hold` cycles.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] pcv, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_ill,
                        input logic [3:0] exp_op, input int hold);
    int cyc = 1;
    int nop = 0;
    issue(tag, ins, rs1, rs2, pcv);
    while (!bus.out_valid && cyc < 40) begin
      if (bus.alu_op == exp_op) nop++;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, ".op_cycles"}, 32'(nop), 32'(exp_lat - 1));
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, ".out_data"}, bus.out_data, exp_data);
      check_eq({tag, ".out_rd"}, 32'(bus.out_rd), 32'(ins[11:7]));
      check_eq({tag, ".out_illegal"}, 32'(bus.out_illegal), 32'(exp_ill));
      check_eq({tag, ".idle_alu"}, {bus.alu_in0[27:0], bus.alu_op}, 32'd0);
      check_eq({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check_eq({tag, ".data_at_handoff"}, bus.out_data, exp_data);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".ready_rise"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".out_data"}, bus.out_data, 32'd0);
    check_eq({tag, ".out_rd"}, 32'(bus.out_rd), 32'd0);
    check_eq({tag, ".out_illegal"}, 32'(bus.out_illegal), 32'd0);
    check_eq({tag, ".alu_in0"}, bus.alu_in0, 32'd0);
    check_eq({tag, ".alu_in1"}, bus.alu_in1, 32'd0);
    check_eq({tag, ".alu_op"}, 32'(bus.alu_op), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0000_0013;
    bus.rs1_val   = 32'd0;
    bus.rs2_val   = 32'd0;
    bus.pc        = 32'd0;
    bus.out_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("por.ready_after", 32'(bus.in_ready), 32'd1);

    run_op("add", r_ins(7'h00, 3'b000, 5'd3), 32'd5, 32'd7, 32'd0, 2, 32'd12, 1'b0, 4'b0010, 1);
    run_op("sub", r_ins(7'h20, 3'b000, 5'd9), 32'd3, 32'd5, 32'd0, 2, 32'hFFFF_FFFE, 1'b0,
           4'b0011, 1);
    run_op("srai4", {7'h20, 5'd4, 5'd1, 3'b101, 5'd4, 7'b0010011}, 32'h8000_0000, 32'd0,
           32'd0, 5, 32'hF800_0000, 1'b0, 4'b0100, 1);
    run_op("sll0", r_ins(7'h00, 3'b001, 5'd5), 32'hDEAD_BEEF, 32'h20, 32'd0, 1, 32'hDEAD_BEEF,
           1'b0, 4'b0111, 1);
    run_op("srl3", r_ins(7'h00, 3'b101, 5'd10), 32'h0000_00F0, 32'd3, 32'd0, 4, 32'h0000_001E,
           1'b0, 4'b0110, 1);
    run_op("lui", {20'h12345, 5'd6, 7'b0110111}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h55, 2,
           32'h1234_5000, 1'b0, 4'b1000, 1);
    run_op("auipc", {20'h00001, 5'd7, 7'b0010111}, 32'hFFFF_FFFF, 32'd0, 32'h100, 2,
           32'h0000_1100, 1'b0, 4'b1000, 1);
    run_op("andi", i_ins(12'h0F0, 3'b111, 5'd11), 32'h0000_00FF, 32'hFFFF_FFFF, 32'd0, 2,
           32'h0000_00F0, 1'b0, 4'b0000, 1);
    run_op("ori", i_ins(12'hFF0, 3'b110, 5'd12), 32'd1, 32'd0, 32'd0, 2, 32'hFFFF_FFF1, 1'b0,
           4'b0001, 1);
    run_op("xor", r_ins(7'h00, 3'b100, 5'd8), 32'h1234, 32'h5678, 32'd0, 1, 32'd0, 1'b1,
           4'b0000, 3);
    run_op("mul", r_ins(7'h01, 3'b000, 5'd13), 32'd6, 32'd7, 32'd0, 1, 32'd0, 1'b1, 4'b0000, 1);

    // SLLI by 31, reset pulsed in cycle T+10 while still shifting.
    issue("slli31", {7'h00, 5'd31, 5'd1, 3'b001, 5'd14, 7'b0010011}, 32'd1, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    check_eq("slli31.mid_op", 32'(bus.alu_op), 32'd7);
    check_eq("slli31.mid_acc", bus.alu_in0, 32'h0000_0200);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst.ready_after", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("midrst.no_valid", 32'(bus.out_valid), 32'd0);
    run_op("addi", i_ins(12'hFFF, 3'b000, 5'd15), 32'd1, 32'd0, 32'd0, 2, 32'd0, 1'b0,
           4'b0010, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits in front of the 32-bit ALU and drives its operand and opcode inputs. It accepts one RV32I integer instruction with its register operands over a valid/ready handshake, decodes it into the ALU's 4-bit opcode encoding, and runs the ALU for one cycle, or for `shamt` cycles on shifts, because the ALU shifts by exactly one bit per operation. It returns the result and destination register over a second valid/ready handshake to writeback.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  controller can accept an instruction.
- `instr`  in  32  RV32I instruction word.
- `rs1_val`  in  32  rs1 operand.
- `rs2_val`  in  32  rs2 operand.
- `pc`  in  32  instruction address, used by AUIPC.
- `alu_in0`  out  32  ALU operand 0.
- `alu_in1`  out  32  ALU operand 1.
- `alu_op`  out  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SRA-by-1, 0110 SRL-by-1, 0111 SLL-by-1, 1000 `{in0[19:0],12'b0}+in1`.
- `alu_out`  in  32  combinational ALU result for the current `alu_in0`/`alu_in1`/`alu_op`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  32  result.
- `out_rd`  out  5  destination register, `instr[11:7]`.
- `out_illegal`  out  1  instruction not supported by this block.

## Operation
**Decode**
- Opcode 0110011 (R-type), funct7/funct3:
  - ADD 0000000/000
  - SUB 0100000/000
  - AND 0000000/111
  - OR 0000000/110
  - SLL 0000000/001
  - SRL 0000000/101
  - SRA 0100000/101
- Opcode 0010011 (I-type):
  - ADDI/ANDI/ORI use imm = sign-extended `instr[31:20]`.
  - SLLI/SRLI/SRAI use shamt = `instr[24:20]`, with funct7 as for the R-type shifts.
- Opcode 0110111 (LUI): `alu_in0` = `instr[31:12]` zero-extended, `alu_in1` = 0, op 1000.
- Opcode 0010111 (AUIPC): as LUI, but `alu_in1` = `pc`.
- For R-type shifts, shamt = `rs2_val[4:0]`.
- Anything else, including XOR, SLT and any funct7 mismatch, is illegal.

**State machine: IDLE, EXEC, SHIFT, DONE**
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch operands, op, rd, shamt and the illegal flag.
  - Next state:
    - Illegal → DONE, with data 0 and `out_illegal`=1.
    - Shift with shamt=0 → DONE, with data = `rs1_val`.
    - Other shift → SHIFT, with the accumulator = `rs1_val` and the counter = shamt.
    - Otherwise → EXEC.
- **EXEC**
  - Drive latched operands and op.
  - At the clock edge, capture `alu_out` into `out_data` and go to DONE.
- **SHIFT**
  - Drive `alu_in0` = accumulator, `alu_in1` = 0, op = 0100/0110/0111.
  - Each edge: accumulator ← `alu_out`, counter ← counter−1.
  - When the counter was 1, go to DONE with `out_data` = `alu_out`.
- **DONE**
  - `out_valid`=1; `out_data`/`out_rd`/`out_illegal` stay stable.
  - On `out_ready`, go to IDLE.

**General rules**
- Outside EXEC/SHIFT, `alu_in0`=`alu_in1`=0 and `alu_op`=0000.
- `in_ready` is high only in IDLE. One instruction is in flight at a time, so no accept overlaps with a pending result.
- Arithmetic wraps modulo 2^32; carry/overflow are ignored.
- Reset (any cycle, including mid-SHIFT or during DONE backpressure):
  - State goes to IDLE and the in-flight instruction is discarded.
  - Reset values: `in_ready`=0 while `rst_n` is low, 1 after release; `out_valid`=0; `out_data`=0; `out_rd`=0; `out_illegal`=0; ALU outputs 0/0/0000.

## Timing
- Accept edge = T.
- Non-shift legal instruction: EXEC in cycle T+1, `out_valid` high from T+2.
- Shift by n>0: SHIFT for cycles T+1..T+n, `out_valid` high from T+n+1.
- Shift by 0 or illegal: `out_valid` high from T+1.
- `out_valid` falls the cycle after the edge where `out_valid`&&`out_ready` holds. `in_ready` rises in that same cycle.
- Next accept is no earlier than one cycle after handoff. Peak throughput is one instruction per 3 cycles for non-shifts.
- `out_ready` has no combinational path to `in_ready`, and `in_valid` has no combinational path to ALU outputs.

## Test plan
- ADD, `rs1`=5, `rs2`=7 → `out_data`=12, `out_rd`=`instr[11:7]`; `out_valid` at T+2; `alu_op`=0010 in T+1 only.
- SRAI shamt=4, `rs1`=0x80000000 → `out_data`=0xF8000000 at T+5; `alu_op`=0100 for exactly 4 cycles.
- SLL, `rs2_val`=0x20 (shamt 0), `rs1`=0xDEADBEEF → `out_data`=0xDEADBEEF at T+1, ALU never driven.
- LUI imm 0x12345 → 0x12345000. AUIPC imm 0x00001, `pc`=0x100 → 0x00001100.
- XOR issued, then `out_ready` held low 3 cycles:
  - `out_illegal`=1, `out_data`=0, both stable.
  - `in_ready`=0 throughout.
  - Handoff on the 4th cycle, `in_ready`=1 the next cycle.
- SLLI shamt=31, `rst_n` pulsed low at T+10:
  - All outputs at reset values immediately, no `out_valid`.
  - A subsequent ADDI `rs1`=1, imm=−1 → 0.
